updown_counter: RTL and testbench
=================================

# updown_counter

Synchronous modulo-N up/down counter with parallel load and cascade outputs. It counts both ways, where the existing T-flip-flop chain only counts up. It is the counting element for BCD/decade chains, timers and FIFO occupancy tracking. It is built from the library's D-flip-flop behaviour, but its reset is synchronous.

## Interface
Parameters:
- WIDTH, 4, counter register width in bits.
- MODULO, 16, count range is 0..MODULO-1. Requires 2 <= MODULO <= 2^WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- ar  input  1  reset, synchronous, active-high; forces q to 0 on the next rising edge.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  parallel load strobe.
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational; used as the en of the next stage in a cascade.
- wrap  output  1  registered one-cycle pulse after a wrap or saturation event.

## Operation
Per-edge priority, highest first:
1. ar: q <= 0, wrap <= 0.
2. load: q <= din. If din >= MODULO, q <= MODULO-1 (clamped). wrap <= 0. en and up are ignored.
3. en & up: if q == MODULO-1, q <= 0 and wrap <= 1; otherwise q <= q+1 and wrap <= 0.
4. en & ~up: if q == 0, q <= MODULO-1 and wrap <= 1; otherwise q <= q-1 and wrap <= 0.
5. Otherwise: q holds, wrap <= 0.

Rules:
- tc = en & ~load & ((up & q == MODULO-1) | (~up & q == 0)). tc is not gated by ar.
- Arithmetic is WIDTH bits with explicit compare against MODULO-1. Natural binary overflow is never relied on, so the count behaves correctly when MODULO < 2^WIDTH.
- Direction may change on any cycle. The step uses up as sampled on that edge, and there is no turnaround penalty.
- Simultaneous ar and load: ar wins. Simultaneous load and en: load wins.
- Reset mid-count: q is 0 on the edge where ar is sampled high. No partial step occurs.
- Illegal states (q >= MODULO, reachable only via X or SEU) recover on the next count: up goes to 0, down goes to MODULO-1.

## Timing
- Reset values: q = 0, wrap = 0. tc follows its equation from q = 0, so tc = en & ~load & ~up.
- Latency: q updates one clock after en, load or ar is sampled.
- wrap is high for exactly the one cycle after a terminal step.
- tc is valid in the same cycle as q, en, up and load. A cascade stage sampling tc as its en therefore steps on the same edge as the stage below it.
- No combinational path from din to any output.

## Configuration
- UPDOWN_COUNTER_SATURATE_EN: when defined, the counter saturates instead of wrapping.
  - Up at MODULO-1 holds MODULO-1.
  - Down at 0 holds 0.
  - wrap pulses on each attempted step past an end.
  - tc is unchanged.
- When undefined, the counter uses modulo wrap as described in Operation.

## Test plan
Each scenario uses WIDTH=4, MODULO=10 unless stated.
- Reset: ar=1 for 1 cycle with en=1, up=1 -> q=0 and wrap=0 after the edge; q=1 one edge after ar is released.
- Up wrap: count up from 0 -> q steps 0..9. tc=1 while q=9. Next q=0, with wrap=1 for one cycle.
- Down wrap: load 0, then up=0, en=1 -> tc=1 at q=0. Next q=9, with wrap=1 for one cycle.
- Load priority and clamp: load=1, din=4'hC, en=1, up=1 -> q=9 (clamped). With ar=1 and load=1 together, din=5 -> q=0.
- Direction flip and hold: at q=5, alternate up=1/0 each cycle -> q=6,5,6,5. With en=0, q holds 5 and tc stays 0.
- Cascade: two instances where the upper stage's en is the lower stage's tc; 100 up-steps from 00 -> 99 then 00. UPDOWN_COUNTER_SATURATE_EN build: 12 up-steps from 0 -> q sticks at 9 with three wrap pulses.

Source files
------------

// File: rtl/updown_counter.sv
// Synchronous modulo-MODULO up/down counter with parallel load, terminal-count and wrap outputs.
// Define UPDOWN_COUNTER_SATURATE_EN to make the count stop at either end instead of wrapping.
module updown_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             at_top;
    logic             at_bot;
    logic             illegal;

    assign at_top  = (q == MAX);
    assign at_bot  = (q == '0);
    assign illegal = (q > MAX);

    assign tc = en & ~load & ((up & at_top) | (~up & at_bot));

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (din > MAX) ? MAX : din;
        end else if (en && up) begin
            if (at_top) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                q_next = MAX;
`else
                q_next = '0;
`endif
                wrap_next = 1'b1;
            end else if (illegal) begin
                q_next = '0;
            end else begin
                q_next = q + WIDTH'(1);
            end
        end else if (en && !up) begin
            if (at_bot) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                q_next = '0;
`else
                q_next = MAX;
`endif
                wrap_next = 1'b1;
            end else if (illegal) begin
                // An out-of-range count re-enters the range from the top.
                q_next = MAX;
            end else begin
                q_next = q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ar) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter (WIDTH=4, MODULO=10) against an integer reference model.
module tb_updown_counter;

  localparam int W   = 4;
  localparam int MOD = 10;
`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         ar = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic         tc, wrap;

  logic         c_ar = 1'b0, c_en = 1'b0, c_up = 1'b0, c_load = 1'b0;
  logic [W-1:0] c_din = '0;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_tc, hi_tc, lo_wrap, hi_wrap;

  updown_counter #(.WIDTH(W), .MODULO(MOD)) dut (
    .clk(clk), .ar(ar), .en(en), .up(up), .load(load), .din(din),
    .q(q), .tc(tc), .wrap(wrap)
  );

  updown_counter #(.WIDTH(W), .MODULO(MOD)) lo_stage (
    .clk(clk), .ar(c_ar), .en(c_en), .up(c_up), .load(c_load), .din(c_din),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
  );

  updown_counter #(.WIDTH(W), .MODULO(MOD)) hi_stage (
    .clk(clk), .ar(c_ar), .en(lo_tc), .up(c_up), .load(c_load), .din(c_din),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  int mq = 0;
  bit mw = 1'b0;

  function automatic bit model_tc(input int cq, input bit e, input bit l, input bit u);
    return e && !l && ((u && cq == MOD - 1) || (!u && cq == 0));
  endfunction

  function automatic void model_step(input int cq, input bit a, input bit l, input bit e,
                                     input bit u, input int d, output int nq, output bit nw);
    nq = cq;
    nw = 1'b0;
    if (a) begin
      nq = 0;
    end else if (l) begin
      nq = (d >= MOD) ? MOD - 1 : d;
    end else if (e && u) begin
      if (cq == MOD - 1) begin
        nq = SAT ? MOD - 1 : 0;
        nw = 1'b1;
      end else begin
        nq = cq + 1;
      end
    end else if (e && !u) begin
      if (cq == 0) begin
        nq = SAT ? 0 : MOD - 1;
        nw = 1'b1;
      end else begin
        nq = cq - 1;
      end
    end
  endfunction

  // driver tasks
  task automatic drive(input bit a, input bit l, input bit e, input bit u, input int d);
    ar = a; load = l; en = e; up = u; din = W'(d);
    #1;
  endtask

  task automatic tick();
    int nq;
    bit nw;
    model_step(mq, ar, load, en, up, int'(din), nq, nw);
    @(posedge clk);
    #1;
    mq = nq;
    mw = nw;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 1, 0);
    tick();
    tests_run++;
    if (q !== W'(mq) || q !== '0) begin
      tests_failed++; $display("FAIL reset_q: got %0d want 0", q);
    end
    tests_run++;
    if (wrap !== 1'b0) begin
      tests_failed++; $display("FAIL reset_wrap: got %0b want 0", wrap);
    end
    drive(0, 0, 1, 1, 0);
    tests_run++;
    if (tc !== model_tc(mq, en, load, up)) begin
      tests_failed++; $display("FAIL reset_tc: got %0b want %0b", tc, model_tc(mq, en, load, up));
    end
    tick();
    tests_run++;
    if (q !== W'(mq) || q !== W'(1)) begin
      tests_failed++; $display("FAIL reset_release_q: got %0d want 1", q);
    end
  endtask

  task automatic test_up_wrap();
    int pulses = 0;
    drive(1, 0, 0, 1, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 1, 0);
      tests_run++;
      if (tc !== model_tc(mq, en, load, up)) begin
        tests_failed++; $display("FAIL up_tc[%0d]: q=%0d got %0b want %0b", i, q, tc, model_tc(mq, en, load, up));
      end
      tick();
      if (wrap) pulses++;
      tests_run++;
      if (q !== W'(mq) || wrap !== mw) begin
        tests_failed++; $display("FAIL up_step[%0d]: got q=%0d wrap=%0b want q=%0d wrap=%0b", i, q, wrap, mq, mw);
      end
    end
    tests_run++;
    if (pulses !== (SAT ? 3 : 1)) begin
      tests_failed++; $display("FAIL up_wrap_pulses: got %0d want %0d", pulses, SAT ? 3 : 1);
    end
  endtask

  task automatic test_down_wrap();
    drive(0, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0);
      tests_run++;
      if (tc !== model_tc(mq, en, load, up)) begin
        tests_failed++; $display("FAIL down_tc[%0d]: got %0b want %0b", i, tc, model_tc(mq, en, load, up));
      end
      tick();
      tests_run++;
      if (q !== W'(mq) || wrap !== mw) begin
        tests_failed++; $display("FAIL down_step[%0d]: got q=%0d wrap=%0b want q=%0d wrap=%0b", i, q, wrap, mq, mw);
      end
    end
  endtask

  task automatic test_load();
    drive(0, 1, 1, 1, 12);
    tests_run++;
    if (tc !== 1'b0) begin
      tests_failed++; $display("FAIL load_tc_masked: got %0b want 0", tc);
    end
    tick();
    tests_run++;
    if (q !== W'(mq) || q !== W'(MOD - 1)) begin
      tests_failed++; $display("FAIL load_clamp: got %0d want %0d", q, MOD - 1);
    end
    drive(1, 1, 0, 0, 5);
    tick();
    tests_run++;
    if (q !== W'(mq) || q !== '0) begin
      tests_failed++; $display("FAIL ar_over_load: got %0d want 0", q);
    end
  endtask

  task automatic test_flip_hold();
    drive(0, 1, 0, 0, 5);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i % 2) == 0, 0);
      tick();
      tests_run++;
      if (q !== W'(mq) || q !== W'((i % 2) == 0 ? 6 : 5)) begin
        tests_failed++; $display("FAIL flip[%0d]: got %0d want %0d", i, q, mq);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, i[0], 0);
      tests_run++;
      if (tc !== 1'b0) begin
        tests_failed++; $display("FAIL hold_tc[%0d]: got %0b want 0", i, tc);
      end
      tick();
      tests_run++;
      if (q !== W'(5) || wrap !== 1'b0) begin
        tests_failed++; $display("FAIL hold_q[%0d]: got q=%0d wrap=%0b want q=5 wrap=0", i, q, wrap);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1), $urandom_range(0, 15));
      tests_run++;
      if (tc !== model_tc(mq, en, load, up)) begin
        tests_failed++; $display("FAIL rand_tc[%0d]: got %0b want %0b", i, tc, model_tc(mq, en, load, up));
      end
      tick();
      tests_run++;
      if (q !== W'(mq) || wrap !== mw) begin
        tests_failed++; $display("FAIL rand_step[%0d]: got q=%0d wrap=%0b want q=%0d wrap=%0b", i, q, wrap, mq, mw);
      end
    end
  endtask

  task automatic test_cascade();
    int value;
    c_ar = 1'b1; c_en = 1'b0; c_up = 1'b1; c_load = 1'b0;
    @(posedge clk); #1;
    c_ar = 1'b0; c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      value = int'(hi_q) * 10 + int'(lo_q);
      tests_run++;
      if (value !== (i % 100)) begin
        tests_failed++; $display("FAIL cascade[%0d]: got %0d want %0d", i, value, i % 100);
      end
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_flip_hold();
    test_random();
    if (!SAT) test_cascade();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
